// File: rtl/fpu_seq_pkg.sv
// rtl/fpu_seq_pkg.sv - shared types and constants for the FP op sequencer
package fpu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2,
        ILL  = 2'd3
    } seq_state_t;

    localparam logic [6:0] F7_FADD = 7'b0000000;
    localparam logic [6:0] F7_FSUB = 7'b0000100;
    localparam logic [6:0] F7_FMUL = 7'b0001000;
    localparam logic [6:0] F7_FDIV = 7'b0001100;

    localparam logic [2:0] FRM_DYN = 3'b111;

    localparam int NV = 4;
    localparam int DZ = 3;
    localparam int OF = 2;
    localparam int UF = 1;
    localparam int NX = 0;

    function automatic logic f7_legal(input logic [6:0] f7);
        return (f7 == F7_FADD) || (f7 == F7_FSUB) || (f7 == F7_FMUL) || (f7 == F7_FDIV);
    endfunction

endpackage

// File: rtl/fpu_frm_resolve.sv
// rtl/fpu_frm_resolve.sv - resolves dynamic rounding mode and flags reserved encodings
module fpu_frm_resolve
    import fpu_seq_pkg::*;
(
    input  logic [2:0] req_frm_i,
    input  logic [2:0] fcsr_frm_i,
    output logic [2:0] frm_o,
    output logic       frm_illegal_o
);

    assign frm_o         = (req_frm_i == FRM_DYN) ? fcsr_frm_i : req_frm_i;
    // 101/110 are reserved, and 111 after resolution means fcsr itself held DYN
    assign frm_illegal_o = (frm_o == 3'b101) || (frm_o == 3'b110) || (frm_o == 3'b111);

endmodule

// File: rtl/fpu_op_sequencer.sv
// rtl/fpu_op_sequencer.sv - holds FP op operands for a per-op latency, then writes back
// Optional: FPU_SEQ_PIPELINE_EN accepts the next request during WB/ILL.
module fpu_op_sequencer
    import fpu_seq_pkg::*;
#(
    parameter int ADD_LAT = 2,
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 12,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [6:0]  req_funct_7,
    input  logic [4:0]  req_rs1,
    input  logic [4:0]  req_rs2,
    input  logic [4:0]  req_rd,
    input  logic [2:0]  req_frm,
    input  logic [2:0]  fcsr_frm,
    input  logic [31:0] fpu_out,
    input  logic [4:0]  fpu_flags,
    input  logic        flags_clr,
    output logic [4:0]  f_rs1,
    output logic [4:0]  f_rs2,
    output logic [6:0]  funct_7,
    output logic [2:0]  frm,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] f_w_data,
    output logic        f_ready,
    output logic [4:0]  f_flags,
    output logic        illegal,
    output logic        busy
);

    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] lat_cnt;
    logic [4:0]       rs1_q, rs2_q, rd_q;
    logic [6:0]       f7_q;
    logic [2:0]       frm_q;
    logic [4:0]       flags_q;
    logic [2:0]       frm_res;
    logic             frm_ill;
    logic             accept;

    fpu_frm_resolve u_frm_resolve (
        .req_frm_i     (req_frm),
        .fcsr_frm_i    (fcsr_frm),
        .frm_o         (frm_res),
        .frm_illegal_o (frm_ill)
    );

`ifdef FPU_SEQ_PIPELINE_EN
    assign req_ready = (state_q == IDLE) || (state_q == WB) || (state_q == ILL);
`else
    assign req_ready = (state_q == IDLE);
`endif
    assign accept = req_valid && req_ready;

    always_comb begin
        lat_cnt = CNT_W'(ADD_LAT - 1);
        if (req_funct_7 == F7_FMUL) lat_cnt = CNT_W'(MUL_LAT - 1);
        if (req_funct_7 == F7_FDIV) lat_cnt = CNT_W'(DIV_LAT - 1);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            EXEC: begin
                if (cnt_q == '0) state_d = WB;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            WB, ILL: state_d = IDLE;
            default: ;
        endcase
        // An accepted request overrides the WB/ILL->IDLE return when pipelined
        if (accept) begin
            if (!f7_legal(req_funct_7) || frm_ill) begin
                state_d = ILL;
            end else begin
                state_d = EXEC;
                cnt_d   = lat_cnt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            f7_q    <= '0;
            frm_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                rs1_q <= req_rs1;
                rs2_q <= req_rs2;
                rd_q  <= req_rd;
                f7_q  <= req_funct_7;
                frm_q <= frm_res;
            end
            if (state_q == WB)  flags_q <= (flags_clr ? 5'b0 : flags_q) | fpu_flags;
            else if (flags_clr) flags_q <= '0;
        end
    end

    assign f_rs1    = rs1_q;
    assign f_rs2    = rs2_q;
    assign funct_7  = f7_q;
    assign frm      = frm_q;
    assign wb_valid = (state_q == WB);
    assign f_ready  = wb_valid;
    assign wb_rd    = wb_valid ? rd_q : 5'b0;
    assign f_w_data = wb_valid ? fpu_out : 32'b0;
    assign f_flags  = flags_q;
    assign illegal  = (state_q == ILL);
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// tb/tb_fpu_op_sequencer.sv - directed self-checking bench for fpu_op_sequencer
module tb_fpu_op_sequencer;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        req_valid;
    logic        req_ready;
    logic [6:0]  req_funct_7;
    logic [4:0]  req_rs1, req_rs2, req_rd;
    logic [2:0]  req_frm, fcsr_frm;
    logic [31:0] fpu_out;
    logic [4:0]  fpu_flags;
    logic        flags_clr;
    logic [4:0]  f_rs1, f_rs2;
    logic [6:0]  funct_7;
    logic [2:0]  frm;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] f_w_data;
    logic        f_ready;
    logic [4:0]  f_flags;
    logic        illegal;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int wb_seen;
    logic [7:0] mask;

    always #5 clk = ~clk;

    fpu_op_sequencer dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_funct_7 (req_funct_7),
        .req_rs1     (req_rs1),
        .req_rs2     (req_rs2),
        .req_rd      (req_rd),
        .req_frm     (req_frm),
        .fcsr_frm    (fcsr_frm),
        .fpu_out     (fpu_out),
        .fpu_flags   (fpu_flags),
        .flags_clr   (flags_clr),
        .f_rs1       (f_rs1),
        .f_rs2       (f_rs2),
        .funct_7     (funct_7),
        .frm         (frm),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .f_w_data    (f_w_data),
        .f_ready     (f_ready),
        .f_flags     (f_flags),
        .illegal     (illegal),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [6:0] f7, input logic [2:0] rm, input logic [4:0] rd);
        req_valid   = 1'b1;
        req_funct_7 = f7;
        req_frm     = rm;
        req_rd      = rd;
        step();
        req_valid   = 1'b0;
    endtask

    initial begin
        n_rst = 1'b1; req_valid = 1'b0; req_funct_7 = '0; req_rs1 = 5'd1; req_rs2 = 5'd2;
        req_rd = '0; req_frm = '0; fcsr_frm = '0; fpu_out = 32'h40400000; fpu_flags = '0;
        flags_clr = 1'b0;
        step(); step();
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_wb", wb_valid, 1'b0);
        chk("rst_flags", f_flags, 5'b0);
        chk("rst_ill", illegal, 1'b0);
        n_rst = 1'b0;
        step();

        fpu_flags = 5'b00001;
        issue(7'b0000000, 3'b000, 5'd5);
        chk("add_c1_busy", busy, 1'b1);
        chk("add_c1_ready", req_ready, 1'b0);
        chk("add_c1_wb", wb_valid, 1'b0);
        chk("add_c1_rs1", f_rs1, 5'd1);
        chk("add_c1_rs2", f_rs2, 5'd2);
        step();
        chk("add_c2_wb", wb_valid, 1'b0);
        step();
        chk("add_c3_wb", wb_valid, 1'b1);
        chk("add_c3_ready", f_ready, 1'b1);
        chk("add_c3_rd", wb_rd, 5'd5);
        chk("add_c3_data", f_w_data, 32'h40400000);
        step();
        fpu_flags = 5'b0;
        chk("add_c4_wb", wb_valid, 1'b0);
        chk("add_c4_rd", wb_rd, 5'd0);
        chk("add_c4_data", f_w_data, 32'h0);
        chk("add_c4_flags", f_flags, 5'b00001);
        chk("add_c4_ready", req_ready, 1'b1);

        fcsr_frm = 3'b010;
        issue(7'b0001100, 3'b111, 5'd9);
        fcsr_frm = 3'b011;
        for (int i = 1; i <= 12; i++) begin
            chk("div_frm", frm, 3'b010);
            chk("div_f7", funct_7, 7'b0001100);
            chk("div_nowb", wb_valid, 1'b0);
            step();
        end
        chk("div_c13_wb", wb_valid, 1'b1);
        chk("div_c13_rd", wb_rd, 5'd9);
        step();
        chk("div_c14_wb", wb_valid, 1'b0);
        chk("div_flags", f_flags, 5'b00001);

        fcsr_frm = 3'b101;
        issue(7'b0000000, 3'b111, 5'd3);
        chk("frm_ill_c1", illegal, 1'b1);
        chk("frm_ill_c1_wb", wb_valid, 1'b0);
        step();
        chk("frm_ill_c2", illegal, 1'b0);
        chk("frm_ill_c2_wb", wb_valid, 1'b0);
        chk("frm_ill_c2_ready", req_ready, 1'b1);
        fcsr_frm = 3'b000;

        issue(7'b1111111, 3'b000, 5'd4);
        chk("f7_ill_c1", illegal, 1'b1);
        chk("f7_ill_c1_ready", req_ready, 1'b0);
        step();
        chk("f7_ill_c2", illegal, 1'b0);
        chk("f7_ill_c2_ready", req_ready, 1'b1);
        chk("f7_ill_flags", f_flags, 5'b00001);

        flags_clr = 1'b1;
        step();
        flags_clr = 1'b0;
        chk("clr_idle", f_flags, 5'b0);

        issue(7'b0001000, 3'b001, 5'd7);
        step(); step();
        chk("mul1_c3_wb", wb_valid, 1'b0);
        step();
        chk("mul1_c4_wb", wb_valid, 1'b1);
        fpu_flags = 5'b10000;
        step();
        fpu_flags = 5'b0;
        chk("mul1_flags", f_flags, 5'b10000);
        issue(7'b0001000, 3'b001, 5'd8);
        step(); step(); step();
        chk("mul2_c4_wb", wb_valid, 1'b1);
        chk("mul2_c4_rd", wb_rd, 5'd8);
        fpu_flags = 5'b00100;
        flags_clr = 1'b1;
        step();
        fpu_flags = 5'b0;
        flags_clr = 1'b0;
        chk("mul2_flags", f_flags, 5'b00100);

        issue(7'b0001100, 3'b000, 5'd6);
        step();
        chk("rstmid_busy_before", busy, 1'b1);
        n_rst = 1'b1;
        step();
        n_rst = 1'b0;
        chk("rstmid_busy", busy, 1'b0);
        chk("rstmid_ready", req_ready, 1'b1);
        chk("rstmid_flags", f_flags, 5'b0);
        chk("rstmid_rs1", f_rs1, 5'd0);
        chk("rstmid_f7", funct_7, 7'd0);
        wb_seen = 0;
        for (int i = 0; i < 16; i++) begin
            if (wb_valid) wb_seen++;
            step();
        end
        chk("rstmid_no_wb", wb_seen, 0);
        chk("rstmid_flags_after", f_flags, 5'b0);

        mask = '0;
        req_valid = 1'b1; req_funct_7 = 7'b0000000; req_frm = 3'b000; req_rd = 5'd2;
        step();
        for (int c = 1; c <= 7; c++) begin
            mask[c] = wb_valid;
            step();
        end
        req_valid = 1'b0;
`ifdef FPU_SEQ_PIPELINE_EN
        chk("b2b_wb_cycles", mask, 8'b0100_1000);
`else
        chk("b2b_wb_cycles", mask, 8'b1000_1000);
`endif
        step(); step(); step(); step();
        chk("b2b_drain_busy", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
